// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. It owns the PC, issues credit-limited imem requests and buffers responses for ID.
// Optional macro IF_MISALIGN_EXCP_EN: a misaligned redirect target yields a single trap pseudo-entry instead of a fetch.
module if_fetch #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(64'h0000_0000_8000_0000),
  parameter int              FETCH_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  output logic            if_valid_o,
  input  logic            id_ready_i,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_misalign_o
);

  localparam int            PW       = (FETCH_DEPTH > 1) ? $clog2(FETCH_DEPTH) : 1;
  localparam logic [3:0]    DEPTH_C  = 4'(FETCH_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(FETCH_DEPTH - 1);
  localparam logic [31:0]   NOP      = 32'h0000_0013;

  logic [XLEN-1:0] pc;
  logic            run;
  logic [3:0]      out_cnt, drop_cnt, fifo_cnt, aq_cnt;
  logic [PW-1:0]   f_head, f_tail, aq_head, aq_tail;
  logic [31:0]     instr_mem [FETCH_DEPTH];
  logic [XLEN-1:0] pc_mem    [FETCH_DEPTH];
  logic [XLEN-1:0] aq_mem    [FETCH_DEPTH];
  logic            misal, misal_pend;
  logic [XLEN-1:0] target;
  logic            bad_target;
  logic            req_fire, rsp_fire, keep, push, pop, fifo_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

`ifdef IF_MISALIGN_EXCP_EN
  assign target     = redirect_pc_i;
  assign bad_target = (redirect_pc_i[1:0] != 2'b00);
`else
  assign target     = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign bad_target = 1'b0;
`endif

  // run keeps the request channel quiet while reset is held
  assign imem_req_valid_o = run && !redirect_i && !misal && ((out_cnt + fifo_cnt) < DEPTH_C);
  assign imem_req_addr_o  = pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign rsp_fire         = imem_rsp_valid_i;
  assign keep             = rsp_fire && (drop_cnt == 4'd0);
  assign push             = keep && !redirect_i;
  assign pop              = if_valid_o && id_ready_i && !redirect_i;
  assign fifo_pop         = pop && (fifo_cnt != 4'd0);

  assign if_valid_o    = misal_pend || (fifo_cnt != 4'd0);
  assign if_misalign_o = misal_pend;

  always_comb begin
    if_instr_o = '0;
    if_pc_o    = '0;
    if (misal_pend) begin
      if_instr_o = NOP;
      if_pc_o    = pc;
    end else if (fifo_cnt != 4'd0) begin
      if_instr_o = instr_mem[f_head];
      if_pc_o    = pc_mem[f_head];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      run        <= 1'b0;
      out_cnt    <= '0;
      drop_cnt   <= '0;
      misal      <= 1'b0;
      misal_pend <= 1'b0;
    end else begin
      run     <= 1'b1;
      out_cnt <= out_cnt + {3'd0, req_fire} - {3'd0, rsp_fire};
      if (redirect_i) begin
        // everything still in flight after this cycle belongs to the old path
        pc         <= target;
        drop_cnt   <= out_cnt - {3'd0, rsp_fire};
        misal      <= bad_target;
        misal_pend <= bad_target;
      end else begin
        if (req_fire) pc <= pc + XLEN'(4);
        if (rsp_fire && (drop_cnt != 4'd0)) drop_cnt <= drop_cnt - 4'd1;
        if (pop) misal_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_head   <= '0;
      f_tail   <= '0;
      fifo_cnt <= '0;
      aq_head  <= '0;
      aq_tail  <= '0;
      aq_cnt   <= '0;
    end else if (redirect_i) begin
      f_head   <= '0;
      f_tail   <= '0;
      fifo_cnt <= '0;
      aq_head  <= '0;
      aq_tail  <= '0;
      aq_cnt   <= '0;
    end else begin
      if (push)     f_tail  <= nxt(f_tail);
      if (fifo_pop) f_head  <= nxt(f_head);
      if (req_fire) aq_tail <= nxt(aq_tail);
      if (keep)     aq_head <= nxt(aq_head);
      fifo_cnt <= fifo_cnt + {3'd0, push} - {3'd0, fifo_pop};
      aq_cnt   <= aq_cnt + {3'd0, req_fire} - {3'd0, keep};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[f_tail] <= imem_rsp_data_i;
      pc_mem[f_tail]    <= aq_mem[aq_head];
    end
    if (req_fire) aq_mem[aq_tail] <= pc;
  end

  a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !fifo_pop && (fifo_cnt == DEPTH_C)));
  a_aq_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_fire && !keep && (aq_cnt == DEPTH_C)));
  a_rsp_unrequested: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_fire && (out_cnt == 4'd0)));

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: random stimulus against an in-order memory model and a stream-level expectation model of the fetch stage.
module tb_if_fetch;
  localparam int D = 2;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid_o, imem_req_ready_i;
  logic [63:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        if_valid_o, id_ready_i;
  logic [31:0] if_instr_o;
  logic [63:0] if_pc_o;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        if_misalign_o;

  always #5 clk = ~clk;

  if_fetch #(.XLEN(64), .RESET_PC(RST_PC), .FETCH_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid_o(imem_req_valid_o), .imem_req_ready_i(imem_req_ready_i),
    .imem_req_addr_o(imem_req_addr_o),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rsp_data_i(imem_rsp_data_i),
    .if_valid_o(if_valid_o), .id_ready_i(id_ready_i),
    .if_instr_o(if_instr_o), .if_pc_o(if_pc_o),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_misalign_o(if_misalign_o)
  );

  typedef struct { logic [63:0] addr; int ep; } req_t;

  int          checks = 0;
  int          errors = 0;
  req_t        memq[$];
  logic [63:0] delivered[$];
  logic [63:0] exp_req, exp_head;
  int          buffered, epoch;
  bit          m_misal, m_pend;
  logic        s_req_valid, s_if_valid, s_mis;
  logic [63:0] s_req_addr, s_if_pc;
  logic [31:0] s_if_instr;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ {a[63:48], a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [63:0] getd(input int i);
    return (delivered.size() > i) ? delivered[i] : 64'hdead_dead_dead_dead;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic init_model();
    memq.delete();
    exp_req  = RST_PC;
    exp_head = RST_PC;
    buffered = 0;
    epoch    = 0;
    m_misal  = 0;
    m_pend   = 0;
  endtask

  // One cycle: drive at negedge, compare against the model, then advance the model to the next cycle.
  task automatic step(input bit redir, input logic [63:0] rpc, input bit idr, input bit rdy, input bit want_rsp);
    logic [63:0] tgt;
    bit          ev_req, ev_if, rsp, pop;
    req_t        h;
    @(negedge clk);
    rsp = want_rsp && (memq.size() != 0);
    redirect_i       = redir;
    redirect_pc_i    = rpc;
    id_ready_i       = idr;
    imem_req_ready_i = rdy;
    imem_rsp_valid_i = rsp;
    imem_rsp_data_i  = rsp ? word_of(memq[0].addr) : $urandom;
    #1;
    s_req_valid = imem_req_valid_o;
    s_req_addr  = imem_req_addr_o;
    s_if_valid  = if_valid_o;
    s_if_pc     = if_pc_o;
    s_if_instr  = if_instr_o;
    s_mis       = if_misalign_o;

    ev_req = !redir && !m_misal && (memq.size() + buffered < D);
    ev_if  = m_pend || (buffered != 0);
    chk("req_valid", imem_req_valid_o, ev_req);
    if (ev_req) chk("req_addr", imem_req_addr_o, exp_req);
    chk("if_valid", if_valid_o, ev_if);
    if (ev_if) begin
      chk("if_pc", if_pc_o, exp_head);
      chk("if_instr", if_instr_o, m_pend ? 64'h13 : 64'(word_of(exp_head)));
      chk("if_misalign", if_misalign_o, m_pend);
    end
    if (if_valid_o && idr && !redir) delivered.push_back(if_pc_o);

`ifdef IF_MISALIGN_EXCP_EN
    tgt = rpc;
`else
    tgt = {rpc[63:2], 2'b00};
`endif
    if (rsp) begin
      h = memq.pop_front();
      if (h.ep == epoch && !redir) buffered++;
    end
    if (imem_req_valid_o && rdy) memq.push_back('{imem_req_addr_o, epoch});
    if (ev_req && rdy) exp_req += 64'd4;
    pop = ev_if && idr && !redir;
    if (pop) begin
      if (m_pend) m_pend = 0;
      else begin
        buffered--;
        exp_head += 64'd4;
      end
    end
    if (redir) begin
      epoch++;
      buffered = 0;
      exp_req  = tgt;
      exp_head = tgt;
      m_misal  = (tgt[1:0] != 2'b00);
      m_pend   = m_misal;
    end
  endtask

  task automatic reset_checks();
    chk("rst_req_valid", imem_req_valid_o, 0);
    chk("rst_if_valid", if_valid_o, 0);
    chk("rst_if_instr", if_instr_o, 0);
    chk("rst_if_pc", if_pc_o, 0);
    chk("rst_if_misalign", if_misalign_o, 0);
  endtask

  task automatic rand_run(input int n);
    logic [63:0] t;
    for (int i = 0; i < n; i++) begin
      if ($urandom % 8 == 0) t = 64'hFFFF_FFFF_FFFF_FFF8;
      else t = RST_PC + 64'($urandom_range(0, 1023)) * 64'd4;
      if ($urandom % 4 == 0) t[1:0] = 2'($urandom);
      step($urandom % 16 == 0, t, $urandom % 4 != 0, $urandom % 3 != 0, $urandom % 3 != 0);
    end
  endtask

  initial begin
    redirect_i = 0; redirect_pc_i = '0; id_ready_i = 0;
    imem_req_ready_i = 0; imem_rsp_valid_i = 0; imem_rsp_data_i = '0;
    init_model();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    reset_checks();
    rst_n = 1'b1;

    // first fetches with ID stalled: two requests, then credit exhausted
    step(0, '0, 0, 1, 0);
    chk("lit_first_req_valid", s_req_valid, 1);
    chk("lit_first_req_addr", s_req_addr, 64'h8000_0000);
    step(0, '0, 0, 1, 1);
    chk("lit_second_req_addr", s_req_addr, 64'h8000_0004);
    chk("lit_no_early_valid", s_if_valid, 0);
    step(0, '0, 0, 1, 1);
    chk("lit_first_if_valid", s_if_valid, 1);
    chk("lit_first_if_pc", s_if_pc, 64'h8000_0000);
    chk("lit_credit_full", s_req_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, '0, 0, 1, 1);
      chk("lit_stall_no_req", s_req_valid, 0);
      chk("lit_stall_pc", s_if_pc, 64'h8000_0000);
    end
    delivered.delete();
    for (int i = 0; i < 8; i++) step(0, '0, 1, 1, 1);
    chk("lit_order0", getd(0), 64'h8000_0000);
    chk("lit_order1", getd(1), 64'h8000_0004);
    chk("lit_order2", getd(2), 64'h8000_0008);

    // two requests in flight, redirect coinciding with a stale response
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0, 1);
    step(0, '0, 1, 1, 0);
    step(0, '0, 1, 1, 0);
    delivered.delete();
    step(1, 64'h8000_1000, 1, 1, 1);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 1, 1);
    chk("lit_redir_first", getd(0), 64'h8000_1000);
    chk("lit_redir_second", getd(1), 64'h8000_1004);

    // redirect with buffered entry, in-flight response and pending pop
    for (int i = 0; i < 6; i++) step(0, '0, 1, 0, 1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 1);
    step(1, 64'h8000_3000, 1, 1, 1);
    step(0, '0, 1, 0, 0);
    chk("lit_flush_empty", s_if_valid, 0);
    chk("lit_flush_target", s_req_addr, 64'h8000_3000);

    // memory not ready: address held, then retargeted by a redirect
    for (int i = 0; i < 5; i++) step(0, '0, 1, 0, 0);
    step(1, 64'h8000_2000, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    chk("lit_wait_valid", s_req_valid, 1);
    chk("lit_wait_retarget", s_req_addr, 64'h8000_2000);

    // misaligned redirect target
    step(1, 64'h8000_0102, 0, 1, 0);
    step(0, '0, 0, 1, 0);
`ifdef IF_MISALIGN_EXCP_EN
    chk("lit_mis_no_req", s_req_valid, 0);
    chk("lit_mis_flag", s_mis, 1);
    chk("lit_mis_pc", s_if_pc, 64'h8000_0102);
    chk("lit_mis_instr", s_if_instr, 32'h0000_0013);
`else
    chk("lit_mis_masked_addr", s_req_addr, 64'h8000_0100);
    chk("lit_mis_flag_tied", s_mis, 0);
`endif
    step(0, '0, 1, 1, 1);
    step(1, 64'h8000_0400, 1, 1, 1);

    rand_run(1500);

    // reset in the middle of traffic
    @(negedge clk);
    rst_n = 1'b0;
    redirect_i = 0; imem_rsp_valid_i = 0; id_ready_i = 0; imem_req_ready_i = 0;
    #1;
    reset_checks();
    @(negedge clk);
    init_model();
    rst_n = 1'b1;
    step(0, '0, 1, 1, 0);
    chk("lit_rerst_addr", s_req_addr, 64'h8000_0000);

    rand_run(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
